seg_disp_ctrl: RTL and testbench
================================

// Module: seg_disp_ctrl
// PURPOSE
//  Downstream display stage for the stack calculator. Latches the 8-bit result the controller
//  publishes (top-of-stack / arithmetic result) and drives the 4-digit multiplexed 7-seg display.
//  Hex mode shows 2 hex digits. Decimal mode runs a sequential 8-step double-dabble and shows
//  0..255 with leading-zero blanking. Digits are committed atomically, so the display never tears.
// PARAMETERS
//  REFRESH_DIV  100000  clk cycles per digit slot; legal >= 2 (bench uses 4)
// PORTS
//  clk       in   1  system clock; all state on posedge
//  rst_n     in   1  asynchronous, active-low reset
//  out_val   in   8  value to display (unsigned)
//  out_load  in   1  1-cycle strobe: capture out_val and dec_mode
//  dec_mode  in   1  0 = hex, 1 = unsigned decimal
//  segs      out  7  cathodes {g,f,e,d,c,b,a}, active-low, registered
//  an        out  4  anodes, active-low, one-hot-zero, registered
//  busy      out  1  1 while decimal conversion runs; loads are ignored while high
// BEHAVIOUR
//  Reset (async, rst_n=0):
//   - an=4'b1110, segs=7'b1000000 ('0'), busy=0.
//   - Digit regs = {blank, blank, blank, 0}. Refresh counter = 0, scan index = 0.
//   - Conversion state is cleared. Reset mid-conversion aborts the conversion; no partial commit.
//  FSM states: IDLE, CONV (iteration counter 0..7), COMMIT folded into the last CONV edge.
//   - IDLE: out_load=1 -> capture value.
//     - dec_mode=0: commit on the same edge (E0): d0=val[3:0], d1=val[7:4], d2=d3=blank. Stay IDLE.
//     - dec_mode=1: go to CONV. busy=1 after E0. BCD shift reg = 0.
//   - CONV: edges E1..E8 each do add-3 (any nibble >= 5) then shift left 1 bit.
//     - At E8: commit d0=ones, d1=tens, d2=hundreds, d3=blank. busy=0, return to IDLE.
//     - Load-to-commit latency: 1 clk in hex mode, 9 clks in decimal mode.
//   - out_load while busy=1: ignored completely (no queueing).
//  Blanking (decimal only):
//   - hundreds==0 -> d2 blank.
//   - hundreds==0 && tens==0 -> d1 blank.
//   - d0 is always shown, so 0 displays as '0'.
//   - Hex mode shows both digits, leading zeros included.
//  Scan:
//   - Counter runs 0..REFRESH_DIV-1. At terminal count: counter wraps to 0, index = (index+1) mod 4.
//   - segs and an are updated on that same edge from the committed digit regs.
//   - index 0..3 -> an = 1110, 1101, 1011, 0111.
//   - A commit and a scan tick on the same edge: the scan uses the pre-edge digit value; the new value
//     appears at the next tick for that slot.
//  Glyphs (g..a), 0-F:
//   - 0:1000000  1:1111001  2:0100100  3:0110000
//   - 4:0011001  5:0010010  6:0000010  7:1111000
//   - 8:0000000  9:0010000  A:0001000  b:0000011
//   - C:1000110  d:0100001  E:0000110  F:0001110
//   - blank: 1111111
// TESTING (REFRESH_DIV=4)
//  1. Assert rst_n=0 -> an=1110, segs=1000000, busy=0. Release -> an advances to 1101 after 4 clks.
//  2. Hex load 0xA7 -> within 16 clks see slot0 '7' 1111000, slot1 'A' 0001000, slots2/3 1111111. busy stays 0.
//  3. Decimal load 0xFF -> busy=1 exactly 8 clks. Then slots0..2 show 5,5,2 (0010010, 0010010, 0100100); slot3 blank.
//  4. Decimal 0x07 -> slot0 '7', slots1/2 blank. Decimal 0x64 -> '0','0','1' (tens not blanked). Decimal 0x00 -> '0'.
//  5. Decimal load 200, then out_load with out_val 0x01 at busy cycle 3 -> ignored; display shows 2,0,0.
//  6. rst_n low at busy cycle 4 of a conversion -> busy=0 immediately, display '0', an=1110, no stale digits after release.

Source files
------------

// File: rtl/seg_disp_ctrl.sv
// seg_disp_ctrl
// Display stage for the stack calculator. Latches the published 8-bit result,
// converts it to hex digits immediately or to decimal with an eight-step
// sequential double-dabble, and scans the committed digits onto a 4-digit
// multiplexed, active-low 7-segment display. Digits are committed all at once,
// so the display never shows a mix of old and new digits.

module seg_disp_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] out_val,
    input  logic       out_load,
    input  logic       dec_mode,
    output logic [6:0] segs,
    output logic [3:0] an,
    output logic       busy
);

    localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

    // Digit code: bit 4 set means blank, bits 3:0 hold the hex/BCD nibble.
    localparam logic [4:0] DIG_BLANK = 5'b10000;

    typedef enum logic {
        IDLE,
        CONV
    } state_t;

    state_t      state;
    logic [2:0]  iter;
    logic [19:0] dd_reg;
    logic [19:0] dd_adj;
    logic [19:0] dd_next;
    logic [3:0]  bcd_hund;
    logic [3:0]  bcd_tens;
    logic [3:0]  bcd_ones;
    logic [4:0]  digit [4];

    logic [CW-1:0] refresh_cnt;
    logic [1:0]    scan_idx;
    logic [1:0]    next_idx;

    // Maps a digit code to its active-low {g,f,e,d,c,b,a} cathode pattern.
    function automatic logic [6:0] glyph(input logic [4:0] d);
        logic [6:0] g;
        if (d[4]) begin
            g = 7'b1111111;
        end else begin
            case (d[3:0])
                4'h0: g = 7'b1000000;
                4'h1: g = 7'b1111001;
                4'h2: g = 7'b0100100;
                4'h3: g = 7'b0110000;
                4'h4: g = 7'b0011001;
                4'h5: g = 7'b0010010;
                4'h6: g = 7'b0000010;
                4'h7: g = 7'b1111000;
                4'h8: g = 7'b0000000;
                4'h9: g = 7'b0010000;
                4'hA: g = 7'b0001000;
                4'hB: g = 7'b0000011;
                4'hC: g = 7'b1000110;
                4'hD: g = 7'b0100001;
                4'hE: g = 7'b0000110;
                default: g = 7'b0001110;
            endcase
        end
        return g;
    endfunction

    // Maps a scan index to its active-low one-hot anode pattern.
    function automatic logic [3:0] anode(input logic [1:0] idx);
        logic [3:0] a;
        case (idx)
            2'd0: a = 4'b1110;
            2'd1: a = 4'b1101;
            2'd2: a = 4'b1011;
            default: a = 4'b0111;
        endcase
        return a;
    endfunction

    // One double-dabble step: add 3 to any BCD nibble >= 5, then shift {bcd, bin} left.
    always_comb begin
        dd_adj = dd_reg;
        if (dd_reg[11:8] >= 4'd5) dd_adj[11:8] = dd_reg[11:8] + 4'd3;
        if (dd_reg[15:12] >= 4'd5) dd_adj[15:12] = dd_reg[15:12] + 4'd3;
        if (dd_reg[19:16] >= 4'd5) dd_adj[19:16] = dd_reg[19:16] + 4'd3;
        dd_next  = {dd_adj[18:0], 1'b0};
        bcd_hund = dd_next[19:16];
        bcd_tens = dd_next[15:12];
        bcd_ones = dd_next[11:8];
        next_idx = scan_idx + 2'd1;
    end

    // Load/convert FSM: captures loads when idle and commits all four digit registers together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            iter     <= 3'd0;
            dd_reg   <= 20'd0;
            busy     <= 1'b0;
            digit[0] <= 5'b00000;
            digit[1] <= DIG_BLANK;
            digit[2] <= DIG_BLANK;
            digit[3] <= DIG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (out_load) begin
                        if (dec_mode) begin
                            dd_reg <= {12'd0, out_val};
                            iter   <= 3'd0;
                            busy   <= 1'b1;
                            state  <= CONV;
                        end else begin
                            digit[0] <= {1'b0, out_val[3:0]};
                            digit[1] <= {1'b0, out_val[7:4]};
                            digit[2] <= DIG_BLANK;
                            digit[3] <= DIG_BLANK;
                        end
                    end
                end
                CONV: begin
                    dd_reg <= dd_next;
                    if (iter == 3'd7) begin
                        digit[0] <= {1'b0, bcd_ones};
                        digit[1] <= (bcd_hund == 4'd0 && bcd_tens == 4'd0) ? DIG_BLANK
                                                                           : {1'b0, bcd_tens};
                        digit[2] <= (bcd_hund == 4'd0) ? DIG_BLANK : {1'b0, bcd_hund};
                        digit[3] <= DIG_BLANK;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else begin
                        iter <= iter + 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Scan timer: every REFRESH_DIV clocks advance to the next slot and drive its glyph and anode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            refresh_cnt <= '0;
            scan_idx    <= 2'd0;
            an          <= 4'b1110;
            segs        <= 7'b1000000;
        end else begin
            if (refresh_cnt == CNT_MAX) begin
                refresh_cnt <= '0;
                scan_idx    <= next_idx;
                an          <= anode(next_idx);
                segs        <= glyph(digit[next_idx]);
            end else begin
                refresh_cnt <= refresh_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// tb_seg_disp_ctrl
// Self-checking bench for seg_disp_ctrl with a short refresh period. Expected
// display contents come from plain integer arithmetic on the loaded value.

module tb_seg_disp_ctrl;

    localparam int REFRESH_DIV = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] out_val;
    logic       out_load;
    logic       dec_mode;
    logic [6:0] segs;
    logic [3:0] an;
    logic       busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    seg_disp_ctrl #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .out_val  (out_val),
        .out_load (out_load),
        .dec_mode (dec_mode),
        .segs     (segs),
        .an       (an),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected glyph for a display slot, from the value's digits in the chosen radix.
    function automatic logic [6:0] expect_slot(input int v, input bit dec, input int slot);
        int d;
        d = -1;
        if (!dec) begin
            if (slot == 0) d = v % 16;
            else if (slot == 1) d = v / 16;
        end else begin
            if (slot == 0) d = v % 10;
            else if (slot == 1 && v >= 10) d = (v / 10) % 10;
            else if (slot == 2 && v >= 100) d = v / 100;
        end
        return (d < 0) ? 7'b1111111 : glyph_tab[d];
    endfunction

    function automatic logic [3:0] slot_anode(input int slot);
        return ~(4'b0001 << slot);
    endfunction

    // Waits (bounded) until the given slot is being driven and returns its segments.
    task automatic wait_slot(input int slot, output logic [6:0] s, output bit ok);
        ok = 1'b0;
        s  = 7'bx;
        for (int i = 0; i < 24; i++) begin
            if (an === slot_anode(slot)) begin
                s  = segs;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    // Pulses out_load for one clock at a negedge; returns at the following negedge.
    task automatic do_load(input logic [7:0] v, input bit dec);
        @(negedge clk);
        out_val  = v;
        dec_mode = dec;
        out_load = 1'b1;
        @(negedge clk);
        out_load = 1'b0;
    endtask

    // Checks the four slots against the model after a full refresh round.
    task automatic check_display(input int v, input bit dec, input string name);
        logic [6:0] s;
        bit ok;
        repeat (4 * REFRESH_DIV + 2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            wait_slot(k, s, ok);
            n_checks++;
            if (!ok || s !== expect_slot(v, dec, k)) begin
                n_fail++;
                $display("[TB] FAIL %s slot%0d: got %b (seen=%0d) expected %b",
                         name, k, s, ok, expect_slot(v, dec, k));
            end
        end
    endtask

    task automatic test_reset();
        rst_n    = 1'b0;
        out_load = 1'b0;
        out_val  = 8'h00;
        dec_mode = 1'b0;
        #12;
        n_checks++;
        if (an !== 4'b1110) begin n_fail++; $display("[TB] FAIL reset_an: got %b expected 1110", an); end
        n_checks++;
        if (segs !== 7'b1000000) begin n_fail++; $display("[TB] FAIL reset_segs: got %b expected 1000000", segs); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (an !== 4'b1110) begin n_fail++; $display("[TB] FAIL scan_hold: got %b expected 1110", an); end
        @(negedge clk);
        n_checks++;
        if (an !== 4'b1101) begin n_fail++; $display("[TB] FAIL scan_advance: got %b expected 1101", an); end
        check_display(0, 1'b1, "reset_digits");
    endtask

    // Loads a value, checks the busy window length, then the display contents.
    task automatic test_value(input logic [7:0] v, input bit dec, input string name);
        int cycles;
        do_load(v, dec);
        cycles = 0;
        while (busy === 1'b1 && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (cycles != (dec ? 8 : 0)) begin
            n_fail++;
            $display("[TB] FAIL %s busy_len: got %0d expected %0d", name, cycles, dec ? 8 : 0);
        end
        check_display(int'(v), dec, name);
    endtask

    task automatic test_random();
        logic [7:0] v;
        bit d;
        for (int i = 0; i < 10; i++) begin
            v = 8'($urandom_range(0, 255));
            d = 1'($urandom_range(0, 1));
            test_value(v, d, $sformatf("rand%0d_%0d_%0d", i, v, d));
        end
    endtask

    task automatic test_back_to_back();
        int cycles;
        do_load(8'd200, 1'b1);
        @(negedge clk);
        @(negedge clk);
        out_val  = 8'h01;
        dec_mode = 1'b0;
        out_load = 1'b1;
        @(negedge clk);
        out_load = 1'b0;
        cycles = 3;
        while (busy === 1'b1 && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
        n_checks++;
        if (cycles != 8) begin
            n_fail++;
            $display("[TB] FAIL ignore_busy_len: got %0d expected 8", cycles);
        end
        check_display(200, 1'b1, "ignore_load");
    endtask

    task automatic test_reset_mid();
        int busy_seen;
        test_value(8'h99, 1'b0, "pre_reset_hex");
        do_load(8'd123, 1'b1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_busy: got %b expected 0", busy); end
        n_checks++;
        if (an !== 4'b1110) begin n_fail++; $display("[TB] FAIL midreset_an: got %b expected 1110", an); end
        n_checks++;
        if (segs !== 7'b1000000) begin n_fail++; $display("[TB] FAIL midreset_segs: got %b expected 1000000", segs); end
        @(negedge clk);
        rst_n = 1'b1;
        busy_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (busy !== 1'b0) busy_seen++;
        end
        n_checks++;
        if (busy_seen != 0) begin
            n_fail++;
            $display("[TB] FAIL midreset_resume: got %0d busy cycles expected 0", busy_seen);
        end
        check_display(0, 1'b1, "midreset_digits");
    endtask

    initial begin
        test_reset();
        test_value(8'hA7, 1'b0, "hex_a7");
        test_value(8'hFF, 1'b1, "dec_255");
        test_value(8'h07, 1'b1, "dec_7");
        test_value(8'h64, 1'b1, "dec_100");
        test_value(8'h00, 1'b1, "dec_0");
        test_value(8'h0A, 1'b1, "dec_10");
        test_value(8'h05, 1'b0, "hex_05");
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so a stuck run still reports and terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
